// File: rtl/regfile_write_ctrl_pkg.sv
// regfile_pkg: shared widths, register-file constants and requester encoding.
package regfile_pkg;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NREG     = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

    function automatic logic [NREG-1:0] dec(input logic [AW-1:0] a);
        return NREG'(1) << a;
    endfunction
endpackage

// File: rtl/regfile_write_ctrl_if.sv
// regfile_write_ctrl_if: writeback requests, reservations, hazard query and register-file drive.
interface regfile_write_ctrl_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
);
    logic            alu_valid, alu_ready;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            ld_valid, ld_ready;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_addr;
    logic [AW-1:0]   rd_addr_1, rd_addr_2;
    logic            hazard;
    logic [NREG-1:0] busy_vec;
    logic [AW-1:0]   rf_write_addr;
    logic [DW-1:0]   rf_write_data;
    logic            rf_reg_write;

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
               rsv_valid, rsv_addr, rd_addr_1, rd_addr_2,
        input  alu_ready, ld_ready, hazard, busy_vec, rf_write_addr, rf_write_data, rf_reg_write
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
               rsv_valid, rsv_addr, rd_addr_1, rd_addr_2,
        output alu_ready, ld_ready, hazard, busy_vec, rf_write_addr, rf_write_data, rf_reg_write
    );
endinterface

// File: rtl/regfile_write_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; after a contested grant the pointer moves to the loser.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    req_e ptr_q, ptr_d;

    always_comb begin
        gnt   = reset ? 2'b00 : (&req) ? (ptr_q == REQ_LD ? 2'b10 : 2'b01) : req;
        ptr_d = (advance && &req) ? (ptr_q == REQ_ALU ? REQ_LD : REQ_ALU) : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= REQ_ALU;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: arbitrates ALU/load writebacks into one registered RF write port
// and tracks pending destination registers for hazard detection.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int DW = regfile_pkg::DW,
    parameter int AW = regfile_pkg::AW
) (
    input logic               clk,
    input logic               reset,
    regfile_write_ctrl_if.slave bus
);
    logic [1:0]      req, gnt;
    logic [AW-1:0]   w_addr, rf_write_addr_q, rf_write_addr_d;
    logic [DW-1:0]   w_data, rf_write_data_q, rf_write_data_d;
    logic            rf_reg_write_q, rf_reg_write_d;
    logic [NREG-1:0] busy_q, busy_d, set_vec, clr_vec;

    assign req = {bus.ld_valid, bus.alu_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (|gnt),
        .gnt     (gnt)
    );

    // Busy bits clear on the commit edge (rf_reg_write_q high), a reservation on that edge wins.
    always_comb begin
        w_addr          = gnt[REQ_LD] ? bus.ld_addr : bus.alu_addr;
        w_data          = gnt[REQ_LD] ? bus.ld_data : bus.alu_data;
        rf_write_addr_d = (|gnt) ? w_addr : rf_write_addr_q;
        rf_write_data_d = (|gnt) ? w_data : rf_write_data_q;
        rf_reg_write_d  = (|gnt) && w_addr != AW'(REG_ZERO);
        set_vec         = (bus.rsv_valid && bus.rsv_addr != AW'(REG_ZERO)) ? dec(bus.rsv_addr) : '0;
        clr_vec         = rf_reg_write_q ? dec(rf_write_addr_q) : '0;
        busy_d          = ((busy_q & ~clr_vec) | set_vec) & ~NREG'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
            rf_reg_write_q  <= 1'b0;
            busy_q          <= '0;
        end else begin
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
            rf_reg_write_q  <= rf_reg_write_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.alu_ready     = gnt[REQ_ALU];
    assign bus.ld_ready      = gnt[REQ_LD];
    assign bus.rf_write_addr = rf_write_addr_q;
    assign bus.rf_write_data = rf_write_data_q;
    assign bus.rf_reg_write  = rf_reg_write_q;
    assign bus.busy_vec      = busy_q;
    assign bus.hazard        = (bus.rd_addr_1 != AW'(REG_ZERO) && busy_q[bus.rd_addr_1]) ||
                               (bus.rd_addr_2 != AW'(REG_ZERO) && busy_q[bus.rd_addr_2]);
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed scenario tasks with hand-computed expectations.
module tb_regfile_write_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass = 0;
    int   total = 0;

    regfile_write_ctrl_if bus ();

    regfile_write_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_addr  = 0; bus.ld_data  = 0;
        bus.rsv_valid = 0; bus.rsv_addr = 0;
        bus.rd_addr_1 = 0; bus.rd_addr_2 = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.alu_valid = 1; bus.alu_addr = 5'd3; bus.alu_data = 32'hDEAD;
        #2;
        total++; if (bus.busy_vec !== 32'h0) $display("FAIL reset_busy: got %h expected %h", bus.busy_vec, 32'h0); else pass++;
        total++; if (bus.rf_reg_write !== 1'b0) $display("FAIL reset_we: got %b expected 0", bus.rf_reg_write); else pass++;
        total++; if (bus.rf_write_addr !== 5'd0 || bus.rf_write_data !== 32'h0) $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.rf_write_addr, bus.rf_write_data); else pass++;
        tick();
        total++; if (bus.alu_ready !== 1'b0 || bus.rf_reg_write !== 1'b0) $display("FAIL reset_ready: got ready=%b we=%b expected 0/0", bus.alu_ready, bus.rf_reg_write); else pass++;
        reset = 0;
        bus.alu_valid = 0;
        #1;
    endtask

    task automatic test_alu_write;
        bus.alu_valid = 1; bus.alu_addr = 5'd5; bus.alu_data = 32'h0000_1234;
        #1;
        total++; if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b0) $display("FAIL alu_ready: got alu=%b ld=%b expected 1/0", bus.alu_ready, bus.ld_ready); else pass++;
        tick();
        bus.alu_valid = 0; bus.alu_addr = 5'd17; bus.alu_data = 32'hFFFF_0000;
        total++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd5 || bus.rf_write_data !== 32'h1234) $display("FAIL alu_write: got we=%b addr=%0d data=%h expected 1/5/00001234", bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data); else pass++;
        tick();
        total++; if (bus.rf_reg_write !== 1'b0 || bus.rf_write_addr !== 5'd5 || bus.rf_write_data !== 32'h1234) $display("FAIL alu_hold: got we=%b addr=%0d data=%h expected 0/5/00001234", bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data); else pass++;
    endtask

    task automatic test_round_robin;
        logic exp_ld;
        reset = 1; #1; reset = 0; #1;
        bus.alu_valid = 1; bus.alu_addr = 5'd2; bus.alu_data = 32'h5555;
        bus.ld_valid  = 1; bus.ld_addr  = 5'd3; bus.ld_data  = 32'hAAAA;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_ld = (i % 2) == 1;
            total++; if (bus.alu_ready !== !exp_ld || bus.ld_ready !== exp_ld) $display("FAIL rr_grant%0d: got alu=%b ld=%b expected %b/%b", i, bus.alu_ready, bus.ld_ready, !exp_ld, exp_ld); else pass++;
            tick();
            total++; if (bus.rf_write_addr !== (exp_ld ? 5'd3 : 5'd2) || bus.rf_reg_write !== 1'b1) $display("FAIL rr_write%0d: got addr=%0d we=%b expected %0d/1", i, bus.rf_write_addr, bus.rf_reg_write, exp_ld ? 3 : 2); else pass++;
        end
        total++; if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b0) $display("FAIL rr_contest_alu: got alu=%b ld=%b expected 1/0", bus.alu_ready, bus.ld_ready); else pass++;
        tick();
        bus.ld_valid = 0;
        #1;
        total++; if (bus.alu_ready !== 1'b1) $display("FAIL rr_uncontested: got alu=%b expected 1", bus.alu_ready); else pass++;
        tick();
        bus.ld_valid = 1;
        #1;
        total++; if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b1) $display("FAIL rr_ptr_kept: got alu=%b ld=%b expected 0/1", bus.alu_ready, bus.ld_ready); else pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd7; bus.rd_addr_1 = 5'd7;
        #1;
        total++; if (bus.hazard !== 1'b0) $display("FAIL hz_before_rsv: got %b expected 0", bus.hazard); else pass++;
        tick();
        bus.rsv_valid = 0;
        #1;
        total++; if (bus.hazard !== 1'b1 || bus.busy_vec !== 32'h0000_0080) $display("FAIL hz_rsv: got hz=%b busy=%h expected 1/00000080", bus.hazard, bus.busy_vec); else pass++;
        bus.rd_addr_1 = 0; bus.rd_addr_2 = 5'd7;
        #1;
        total++; if (bus.hazard !== 1'b1) $display("FAIL hz_rd2: got %b expected 1", bus.hazard); else pass++;
        bus.rd_addr_2 = 5'd6;
        #1;
        total++; if (bus.hazard !== 1'b0) $display("FAIL hz_other: got %b expected 0", bus.hazard); else pass++;
        bus.rd_addr_1 = 5'd7; bus.rd_addr_2 = 0;
        bus.ld_valid = 1; bus.ld_addr = 5'd7; bus.ld_data = 32'h77;
        #1;
        total++; if (bus.ld_ready !== 1'b1) $display("FAIL hz_ld_ready: got %b expected 1", bus.ld_ready); else pass++;
        tick();
        bus.ld_valid = 0;
        total++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd7 || bus.hazard !== 1'b1) $display("FAIL hz_commit_cycle: got we=%b addr=%0d hz=%b expected 1/7/1", bus.rf_reg_write, bus.rf_write_addr, bus.hazard); else pass++;
        tick();
        total++; if (bus.hazard !== 1'b0 || bus.busy_vec !== 32'h0) $display("FAIL hz_released: got hz=%b busy=%h expected 0/00000000", bus.hazard, bus.busy_vec); else pass++;
        idle_inputs();
    endtask

    task automatic test_set_wins;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd9;
        tick();
        bus.rsv_valid = 0;
        bus.alu_valid = 1; bus.alu_addr = 5'd9; bus.alu_data = 32'h99;
        tick();
        bus.alu_valid = 0;
        total++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd9) $display("FAIL sw_commit: got we=%b addr=%0d expected 1/9", bus.rf_reg_write, bus.rf_write_addr); else pass++;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd9;
        tick();
        bus.rsv_valid = 0;
        total++; if (bus.busy_vec !== 32'h0000_0200) $display("FAIL sw_set_wins: got %h expected 00000200", bus.busy_vec); else pass++;
        bus.alu_valid = 1;
        tick();
        bus.alu_valid = 0;
        tick();
        total++; if (bus.busy_vec !== 32'h0) $display("FAIL sw_cleared: got %h expected 00000000", bus.busy_vec); else pass++;
    endtask

    task automatic test_zero;
        bus.alu_valid = 1; bus.alu_addr = 5'd0; bus.alu_data = 32'hFFFF;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd0; bus.rd_addr_1 = 0;
        #1;
        total++; if (bus.alu_ready !== 1'b1 || bus.hazard !== 1'b0) $display("FAIL zero_ready: got ready=%b hz=%b expected 1/0", bus.alu_ready, bus.hazard); else pass++;
        tick();
        idle_inputs();
        total++; if (bus.rf_reg_write !== 1'b0 || bus.busy_vec !== 32'h0 || bus.hazard !== 1'b0) $display("FAIL zero_write: got we=%b busy=%h hz=%b expected 0/00000000/0", bus.rf_reg_write, bus.busy_vec, bus.hazard); else pass++;
        tick();
        total++; if (bus.rf_reg_write !== 1'b0 || bus.busy_vec !== 32'h0) $display("FAIL zero_after: got we=%b busy=%h expected 0/00000000", bus.rf_reg_write, bus.busy_vec); else pass++;
    endtask

    task automatic test_reset_mid;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd12;
        tick();
        bus.rsv_valid = 0;
        bus.alu_valid = 1; bus.alu_addr = 5'd4; bus.alu_data = 32'h4444;
        tick();
        total++; if (bus.rf_reg_write !== 1'b1 || bus.busy_vec !== 32'h0000_1000) $display("FAIL mid_pre: got we=%b busy=%h expected 1/00001000", bus.rf_reg_write, bus.busy_vec); else pass++;
        reset = 1;
        #1;
        total++; if (bus.rf_reg_write !== 1'b0 || bus.busy_vec !== 32'h0 || bus.rf_write_addr !== 5'd0 || bus.rf_write_data !== 32'h0) $display("FAIL mid_reset: got we=%b busy=%h addr=%0d data=%h expected 0/00000000/0/00000000", bus.rf_reg_write, bus.busy_vec, bus.rf_write_addr, bus.rf_write_data); else pass++;
        total++; if (bus.alu_ready !== 1'b0) $display("FAIL mid_ready: got %b expected 0", bus.alu_ready); else pass++;
        idle_inputs();
        reset = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_round_robin();
        test_hazard();
        test_set_wins();
        test_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
